axil_master_initiator: RTL and testbench

- AXI4-Lite initiator (master) that converts a simple single-outstanding host command stream into AXI4-Lite read/write transactions.
- It is the initiator-side counterpart of the AXI2SDRAM slave port. It is used in bench harnesses and on-chip test engines to drive the SDRAM bridge.
- One transaction is in flight at a time. Response status, read data and saturating error/transaction counters are returned to the host.

---
 rtl/axil_master_initiator.sv | 257 +++++++++++++++++++++++++
 tb/tb_axil_master_initiator.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_master_initiator.sv
// AXI4-Lite initiator: turns a single-outstanding host command stream into
// AXI4-Lite write or read transactions and returns the response status, the
// read data and saturating transaction/error counters to the host.
module axil_master_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  // host command stream
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // host response stream
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_we,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [CNT_WIDTH-1:0]      wr_count,
  output logic [CNT_WIDTH-1:0]      rd_count,
  output logic [CNT_WIDTH-1:0]      err_count,
  // AXI4-Lite write address channel
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic [2:0]                AWPROT,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  // AXI4-Lite write data channel
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      WVALID,
  input  logic                      WREADY,
  // AXI4-Lite write response channel
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  // AXI4-Lite read address channel
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic [2:0]                ARPROT,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  // AXI4-Lite read data channel
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RVALID,
  output logic                      RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RESP
  } state_t;

  state_t                  state_reg, state_next;
  logic                    awvalid_reg, awvalid_next;
  logic                    wvalid_reg, wvalid_next;
  logic                    aw_done_reg, aw_done_next;
  logic                    w_done_reg, w_done_next;
  logic                    bready_reg, bready_next;
  logic                    arvalid_reg, arvalid_next;
  logic                    rready_reg, rready_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [STRB_WIDTH-1:0]   wstrb_reg, wstrb_next;
  logic                    rsp_valid_reg, rsp_valid_next;
  logic                    rsp_we_reg, rsp_we_next;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]              rsp_resp_reg, rsp_resp_next;

  // counter index 0 = writes, 1 = reads, 2 = error responses
  logic [2:0]              cnt_inc;
  logic [CNT_WIDTH-1:0]    cnt_reg [3];

  // Next-state and next-output logic; every AXI output is taken from a register.
  always_comb begin
    state_next     = state_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    aw_done_next   = aw_done_reg;
    w_done_next    = w_done_reg;
    bready_next    = bready_reg;
    arvalid_next   = arvalid_reg;
    rready_next    = rready_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_we_next    = rsp_we_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_resp_next  = rsp_resp_reg;
    cnt_inc        = 3'b000;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          addr_next  = cmd_addr;
          wdata_next = cmd_wdata;
          wstrb_next = cmd_wstrb;
          if (cmd_we) begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
            state_next   = WR_REQ;
          end else begin
            arvalid_next = 1'b1;
            state_next   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W complete independently; the done flags remember which one
        // has already handshaken so BREADY waits for both.
        if (awvalid_reg && AWREADY) begin
          awvalid_next = 1'b0;
          aw_done_next = 1'b1;
        end
        if (wvalid_reg && WREADY) begin
          wvalid_next = 1'b0;
          w_done_next = 1'b1;
        end
        if (aw_done_next && w_done_next) begin
          bready_next  = 1'b1;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BVALID && bready_reg) begin
          bready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_we_next    = 1'b1;
          rsp_rdata_next = '0;
          rsp_resp_next  = BRESP;
          cnt_inc[0]     = 1'b1;
          cnt_inc[2]     = BRESP[1];
          state_next     = RESP;
        end
      end
      RD_REQ: begin
        if (ARREADY) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (RVALID && rready_reg) begin
          rready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_we_next    = 1'b0;
          rsp_rdata_next = RDATA;
          rsp_resp_next  = RRESP;
          cnt_inc[1]     = 1'b1;
          cnt_inc[2]     = RRESP[1];
          state_next     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg     <= IDLE;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_we_reg    <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= 2'b00;
    end else begin
      state_reg     <= state_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
      bready_reg    <= bready_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_we_reg    <= rsp_we_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_resp_reg  <= rsp_resp_next;
    end
  end

  // Saturating counters: hold at all-ones instead of wrapping.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != CNT_MAX)) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
        end
      end
    end
  endgenerate

  // cmd_ready is masked by the reset input so it is low for the whole reset.
  assign cmd_ready = (state_reg == IDLE) && !ARESET;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_we    = rsp_we_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_resp  = rsp_resp_reg;
  assign wr_count  = cnt_reg[0];
  assign rd_count  = cnt_reg[1];
  assign err_count = cnt_reg[2];

  assign AWADDR  = addr_reg;
  assign AWPROT  = 3'b000;
  assign AWVALID = awvalid_reg;
  assign WDATA   = wdata_reg;
  assign WSTRB   = wstrb_reg;
  assign WVALID  = wvalid_reg;
  assign BREADY  = bready_reg;
  assign ARADDR  = addr_reg;
  assign ARPROT  = 3'b000;
  assign ARVALID = arvalid_reg;
  assign RREADY  = rready_reg;

endmodule

// File: tb/tb_axil_master_initiator.sv
// Bench for axil_master_initiator: directed scenarios followed by randomized
// host/slave traffic, checked every cycle against a transaction-level model.
module tb_axil_master_initiator;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [CW-1:0] wr_count, rd_count, err_count;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0]    AWPROT, ARPROT;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [3:0]    WSTRB;
  logic [1:0]    BRESP, RRESP;

  int total = 0;
  int bad   = 0;

  axil_master_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // One transaction at a time: which handshakes have happened so far decides
  // which VALID/READY must be high in the following cycle.
  logic          m_busy, m_wr, m_aw, m_w, m_b, m_ar, m_r;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [3:0]    m_wstrb;
  logic [1:0]    m_resp;
  int            m_wrc, m_rdc, m_errc, ntx;

  initial ntx = 0;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_busy <= 1'b0; m_wr <= 1'b0;
      m_aw <= 1'b0; m_w <= 1'b0; m_b <= 1'b0; m_ar <= 1'b0; m_r <= 1'b0;
      m_wrc <= 0; m_rdc <= 0; m_errc <= 0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy <= 1'b1; m_wr <= cmd_we;
        m_aw <= 1'b0; m_w <= 1'b0; m_b <= 1'b0; m_ar <= 1'b0; m_r <= 1'b0;
        m_addr <= cmd_addr; m_wdata <= cmd_wdata; m_wstrb <= cmd_wstrb;
      end
    end else if ((m_wr && m_b) || (!m_wr && m_r)) begin
      if (rsp_ready) begin
        m_busy <= 1'b0;
        ntx <= ntx + 1;
        $display("txn %0d: we=%0b addr=%h rdata=%h resp=%0d", ntx, m_wr, m_addr, m_rdata, m_resp);
      end
    end else if (m_wr) begin
      if (m_aw && m_w) begin
        if (BVALID) begin
          m_b <= 1'b1; m_resp <= BRESP; m_rdata <= '0;
          m_wrc <= (m_wrc == CMAX) ? m_wrc : m_wrc + 1;
          if (BRESP[1]) m_errc <= (m_errc == CMAX) ? m_errc : m_errc + 1;
        end
      end else begin
        if (!m_aw && AWREADY) m_aw <= 1'b1;
        if (!m_w && WREADY) m_w <= 1'b1;
      end
    end else begin
      if (m_ar) begin
        if (RVALID) begin
          m_r <= 1'b1; m_resp <= RRESP; m_rdata <= RDATA;
          m_rdc <= (m_rdc == CMAX) ? m_rdc : m_rdc + 1;
          if (RRESP[1]) m_errc <= (m_errc == CMAX) ? m_errc : m_errc + 1;
        end
      end else if (ARREADY) begin
        m_ar <= 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge ACLK) begin
    #1;
    if (ARESET) begin
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 0);
      check("rst_addr_data", {AWADDR, WDATA}, 0);
      check("rst_strb_rsp", {WSTRB, rsp_we, rsp_resp}, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_counts", {wr_count, rd_count, err_count}, 0);
    end else begin
      check("cmd_ready", cmd_ready, !m_busy);
      check("AWVALID", AWVALID, m_busy && m_wr && !m_aw);
      check("WVALID", WVALID, m_busy && m_wr && !m_w);
      check("BREADY", BREADY, m_busy && m_wr && m_aw && m_w && !m_b);
      check("ARVALID", ARVALID, m_busy && !m_wr && !m_ar);
      check("RREADY", RREADY, m_busy && !m_wr && m_ar && !m_r);
      check("rsp_valid", rsp_valid, m_busy && (m_wr ? m_b : m_r));
      check("prot", {AWPROT, ARPROT}, 0);
      if (m_busy && m_wr && !m_aw) check("AWADDR", AWADDR, m_addr);
      if (m_busy && m_wr && !m_w) check("WDATA_WSTRB", {WDATA, WSTRB}, {m_wdata, m_wstrb});
      if (m_busy && !m_wr && !m_ar) check("ARADDR", ARADDR, m_addr);
      if (m_busy && (m_wr ? m_b : m_r)) begin
        check("rsp_we", rsp_we, m_wr);
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("rsp_resp", rsp_resp, m_resp);
      end
      check("wr_count", wr_count, m_wrc[CW-1:0]);
      check("rd_count", rd_count, m_rdc[CW-1:0]);
      check("err_count", err_count, m_errc[CW-1:0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic slave(input logic awr, input logic wr, input logic bv, input logic [1:0] br,
                       input logic arr, input logic rv, input logic [DW-1:0] rd, input logic [1:0] rr);
    AWREADY = awr; WREADY = wr; BVALID = bv; BRESP = br;
    ARREADY = arr; RVALID = rv; RDATA = rd; RRESP = rr;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!rsp_valid) begin
      bad++; total++;
      $display("FAIL %s: rsp_valid never rose (got 0 expected 1)", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!cmd_ready) begin
      bad++; total++;
      $display("FAIL %s: cmd_ready never rose (got 0 expected 1)", name);
    end
  endtask

  initial begin
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0;
    slave(0, 0, 0, 2'b00, 0, 0, '0, 2'b00);
    repeat (2) @(negedge ACLK);
    check("lit_rst_cmd_ready", cmd_ready, 0);
    ARESET = 1'b0;
    #1 check("lit_release_cmd_ready", cmd_ready, 1);
    @(negedge ACLK);

    // zero-wait write
    slave(1, 1, 1, 2'b00, 0, 0, '0, 2'b00);
    rsp_ready = 1'b1;
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    check("lit_w1_valids", {AWVALID, WVALID}, 2'b11);
    check("lit_w1_awaddr", AWADDR, 32'h0000_0010);
    check("lit_w1_wdata", {WDATA, WSTRB}, {32'hDEAD_BEEF, 4'hF});
    wait_rsp("w1_rsp");
    check("lit_w1_rsp", {rsp_we, rsp_resp}, 3'b100);
    check("lit_w1_wr_count", wr_count, 1);
    @(negedge ACLK);
    wait_idle("w1_idle");

    // skewed write: W handshakes at once, AW three cycles later, BVALID early
    slave(0, 1, 1, 2'b00, 0, 0, '0, 2'b00);
    issue(1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3);
    @(negedge ACLK);
    WREADY = 1'b0;
    check("lit_w2_after_w", {AWVALID, WVALID, BREADY}, 3'b100);
    repeat (2) begin
      @(negedge ACLK);
      check("lit_w2_hold", {AWVALID, BREADY}, 2'b10);
      check("lit_w2_early_b", wr_count, 1);
    end
    AWREADY = 1'b1;
    @(negedge ACLK);
    AWREADY = 1'b0;
    check("lit_w2_bready", {AWVALID, BREADY}, 2'b01);
    wait_rsp("w2_rsp");
    check("lit_w2_wr_count", wr_count, 2);
    @(negedge ACLK);
    wait_idle("w2_idle");

    // read with two wait cycles on RVALID
    slave(0, 0, 0, 2'b00, 1, 0, '0, 2'b00);
    issue(1'b0, 32'h0000_0010, '0, 4'h0);
    check("lit_r1_ar", {ARVALID, ARADDR}, {1'b1, 32'h0000_0010});
    @(negedge ACLK);
    check("lit_r1_rready", {ARVALID, RREADY}, 2'b01);
    @(negedge ACLK);
    @(negedge ACLK);
    slave(0, 0, 0, 2'b00, 1, 1, 32'hDEAD_BEEF, 2'b00);
    @(negedge ACLK);
    RVALID = 1'b0;
    check("lit_r1_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("lit_r1_rsp", {rsp_valid, rsp_we}, 2'b10);
    check("lit_r1_rd_count", rd_count, 1);
    @(negedge ACLK);
    wait_idle("r1_idle");

    // slave error with host backpressure
    rsp_ready = 1'b0;
    slave(0, 0, 0, 2'b00, 1, 1, 32'hCAFE_0001, 2'b10);
    issue(1'b0, 32'h0000_0044, '0, 4'h0);
    wait_rsp("e1_rsp");
    RVALID = 1'b0;
    repeat (4) begin
      check("lit_e1_hold", {rsp_valid, rsp_resp, cmd_ready}, 4'b1100);
      check("lit_e1_rdata", rsp_rdata, 32'hCAFE_0001);
      @(negedge ACLK);
    end
    check("lit_e1_counts", {err_count, rd_count}, {2'd1, 2'd2});
    rsp_ready = 1'b1;
    @(negedge ACLK);
    check("lit_e1_release", {rsp_valid, cmd_ready}, 2'b01);

    // saturation: five more writes, wr_count must stop at 3
    for (int i = 0; i < 5; i++) begin
      slave(1, 1, 1, 2'b00, 0, 0, '0, 2'b00);
      issue(1'b1, 32'h100 + 32'(i * 4), 32'(i), 4'hF);
      wait_rsp("sat_rsp");
      @(negedge ACLK);
      wait_idle("sat_idle");
    end
    check("lit_sat_wr_count", wr_count, 3);

    // reset while ARVALID waits for ARREADY
    slave(0, 0, 0, 2'b00, 0, 0, '0, 2'b00);
    issue(1'b0, 32'h0000_0080, '0, 4'h0);
    @(negedge ACLK);
    check("lit_ra_arvalid", ARVALID, 1);
    #2 ARESET = 1'b1;
    #1 check("lit_ra_async", {ARVALID, cmd_ready}, 2'b00);
    check("lit_ra_counts", {wr_count, rd_count, err_count}, 0);
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1 check("lit_ra_idle", cmd_ready, 1);

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge ACLK);
      ARESET    = ($urandom_range(0, 399) == 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_we    = $urandom_range(0, 1);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_wstrb = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      slave($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 1),
            2'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom, 2'($urandom));
    end
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("random_activity", ntx > 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
